inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the combinational instruction memory.
- Owns the PC register and drives the memory word address.
- Captures the returned instruction into a 2-entry queue and presents it to decode over a valid/ready handshake.
- Handles branch, jump and jump-register redirects (with queue flush) and a halt request.

Parameters:
- PC_WIDTH, 32, width of PC and memory address. Addresses are word addresses; sequential PC = PC+1.
- RESET_PC, 0, PC value loaded on reset.
- QUEUE_DEPTH, 2, instruction queue entries. Fixed at 2; other values unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  PC_WIDTH  word address to instruction memory; equals the PC register
- imem_instr  in  32  instruction read combinationally at imem_addr in the same cycle
- branch_taken  in  1  redirect to PC-relative target
- branch_base  in  PC_WIDTH  PC+1 of the branch instruction
- branch_offset  in  16  signed word offset
- jump_en  in  1  redirect to absolute target
- jump_target  in  26  word target field
- jr_en  in  1  redirect to register value
- jr_addr  in  PC_WIDTH  register target (word address)
- halt_req  in  1  stop fetching (syscall/halt)
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  PC_WIDTH  address the head instruction was fetched from
- halted  out  1  halt taken and queue fully drained

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; queue count=0; state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0; imem_addr=RESET_PC.
  - Reset asserted mid-operation discards all queue contents immediately.
- States:
  - RUN -> HALT on halt_req=1.
  - HALT is left only by reset.
- Push (RUN only), every cycle where (count<2) or (count==2 and out_valid and out_ready):
  - Write {imem_instr, PC} at the queue tail.
  - PC <= PC+1, wrapping modulo 2^PC_WIDTH (all-ones -> 0).
  - Without a push, PC holds.
- Pop: a transfer occurs when out_valid and out_ready. The head is removed at that edge.
- Push and pop in the same cycle leave count unchanged. Order is preserved: FIFO, no reordering.
- out_valid = (count != 0). out_instr/out_pc are driven from the head entry, with no combinational path from imem_instr.
- Latency: instruction at address A is visible at out_* the cycle after imem_addr==A (1 cycle). After reset release, the first out_valid=1 is on the first cycle after the first rising edge.
- Redirect priority: jr_en > jump_en > branch_taken.
  - jr target = jr_addr.
  - jump target = {branch_base[PC_WIDTH-1:26], jump_target}.
  - branch target = branch_base + sign_extend(branch_offset), modulo 2^PC_WIDTH.
- Redirect (RUN, any redirect input = 1) at the edge:
  - PC <= target; queue count <= 0 (flush).
  - No push occurs that cycle.
  - A pop in the same cycle still counts as completed.
  - Next cycle: out_valid=0 and imem_addr=target. The target instruction is at out_* one cycle later, giving a 1-bubble penalty.
- Halt:
  - halt_req=1 in RUN: no push that cycle or after; PC frozen.
  - Queue is not flushed; it drains normally.
  - Redirects in the same or later cycles are ignored (halt wins).
- halted=1 when state==HALT and count==0. It stays 1 until reset.
- halt_req and redirect inputs in HALT have no effect.
- Back-pressure: out_ready=0 with count==2 → no push, PC holds, imem_addr stable, head stable.

Test Plan:
- Reset release with RESET_PC=0, memory[k]=k+0x100, out_ready=1 → out_pc = 0,1,2,3 on consecutive cycles; out_instr = 0x100..0x103; no bubbles.
- out_ready=0 for 5 cycles → count saturates at 2, imem_addr frozen at 2, out_pc=0 held. Then out_ready=1 → out_pc sequence 0,1,2 with no loss or duplication.
- branch_taken=1, branch_base=5, branch_offset=0xFFFD (-3) → queue flushed, one out_valid=0 cycle, then out_pc=2. Repeat with jr_en and jump_en asserted together → jr_addr wins.
- jump_en, branch_base=0x0400_0010, jump_target=0x20 → next out_pc=0x0400_0020.
- RESET_PC=0xFFFF_FFFE, continuous ready → out_pc = 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- halt_req with 2 queued and out_ready=1, plus a branch in the same cycle → 2 more instructions delivered, no redirect, then halted=1 and out_valid=0. Later, rst_n=0 mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and buffers
// fetched words in a 2-entry FIFO towards decode, with redirect flush and halt.
module inst_fetch_unit #(
  parameter int                    PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_instr,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_base,
  input  logic [15:0]         branch_offset,
  input  logic                jump_en,
  input  logic [25:0]         jump_target,
  input  logic                jr_en,
  input  logic [PC_WIDTH-1:0] jr_addr,
  input  logic                halt_req,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                halted,
  output logic                state_dbg
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [1:0]          FULL   = 2'(QUEUE_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e              state;
  logic [PC_WIDTH-1:0] pc;
  logic [1:0]          count;
  logic                head;
  logic                tail;
  logic [31:0]         q_instr [2];
  logic [PC_WIDTH-1:0] q_pc    [2];

  logic                running;
  logic                redirect;
  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] target;

  // Handshake: a word transfers to decode on any rising edge where
  // out_valid && out_ready; out_valid never depends on out_ready.
  assign pop      = out_valid && out_ready;
  // A halt request in the same cycle suppresses both push and redirect.
  assign running  = (state == RUN) && !halt_req;
  assign redirect = running && (jr_en || jump_en || branch_taken);
  assign push     = running && !redirect && ((count != FULL) || pop);

  always_comb begin
    target = branch_base + {{(PC_WIDTH-16){branch_offset[15]}}, branch_offset};
    if (jr_en)
      target = jr_addr;
    else if (jump_en)
      target = {branch_base[PC_WIDTH-1:26], jump_target};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      if ((state == RUN) && halt_req)
        state <= HALT;
      if (redirect) begin
        // Flush: the popped head (if any) still completes, everything else is dropped.
        pc    <= target;
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else begin
        if (push) begin
          q_instr[tail] <= imem_instr;
          q_pc[tail]    <= pc;
          tail          <= ~tail;
          pc            <= pc + PC_ONE;
        end
        if (pop)
          head <= ~head;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = q_instr[head];
  assign out_pc    = q_pc[head];
  assign halted    = (state == HALT) && (count == 2'd0);
  assign state_dbg = (state == HALT);

endmodule
